countdown_timer: RTL and testbench

//  Loadable down-counting timer: a period is loaded via valid/ready, counted to zero on

---
 rtl/countdown_timer_pkg.sv | 32 +++
 rtl/countdown_timer_if.sv | 32 +++
 rtl/countdown_timer_tick_prescaler.sv | 56 +++++
 rtl/countdown_timer.sv | 128 ++++++++++++
 tb/tb_countdown_timer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/countdown_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : timer_pkg
//  Description : State encoding and width helpers shared by the countdown timer.
//  Revision    : 1.0
// ============================================================================
package timer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_PAUSE = 2'd2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((longint'(1) << i) < longint'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // A prescaler counter needs at least one bit even when PRESCALE is tiny.
    function automatic int prescaler_width(input int prescale);
        return (clog2(prescale) < 1) ? 1 : clog2(prescale);
    endfunction

endpackage
`default_nettype wire

// File: rtl/countdown_timer_if.sv
`default_nettype none
// ============================================================================
//  Interface   : countdown_timer_if
//  Description : Load handshake, control and status bundle of the countdown timer.
//  Revision    : 1.0
// ============================================================================
interface countdown_timer_if #(
    parameter int W = 32
);
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] load_value;
    logic         periodic;
    logic         start;
    logic         stop;
    logic         clear;
    logic [W-1:0] count;
    logic         busy;
    logic         paused;
    logic         done;

    modport master (
        output load_valid, load_value, periodic, start, stop, clear,
        input  load_ready, count, busy, paused, done
    );

    modport slave (
        input  load_valid, load_value, periodic, start, stop, clear,
        output load_ready, count, busy, paused, done
    );
endinterface
`default_nettype wire

// File: rtl/countdown_timer_tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Emits one tick every PRESCALE enabled cycles; holds while disabled.
//  Revision    : 1.0
// ============================================================================
module tick_prescaler
    import timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic en_i,
    input  wire logic clr_i,
    output logic      tick_o
);

    generate
        if (PRESCALE == 1) begin : g_passthrough
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst, clr_i};
            assign tick_o   = en_i;
        end else begin : g_counter
            localparam int             PW           = prescaler_width(PRESCALE);
            localparam logic [PW-1:0] c_last_phase = PW'(PRESCALE - 1);

            logic [PW-1:0] phase_q;
            logic [PW-1:0] phase_d;
            logic          w_wrap;

            assign w_wrap = (phase_q == c_last_phase);

            always_comb begin
                phase_d = phase_q;
                if (clr_i) begin
                    phase_d = '0;
                end else if (en_i) begin
                    phase_d = w_wrap ? '0 : phase_q + 1'b1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    phase_q <= '0;
                end else begin
                    phase_q <= phase_d;
                end
            end

            assign tick_o = en_i & w_wrap;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer
//  Description : Loadable prescaled down-counter with one-shot/auto-reload modes.
//  Revision    : 1.0
// ============================================================================
module countdown_timer
    import timer_pkg::*;
#(
    parameter int W        = 32,
    parameter int PRESCALE = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    countdown_timer_if.slave   bus
);

    state_t       state_q, state_d;
    logic [W-1:0] count_q, count_d;
    logic [W-1:0] reload_q, reload_d;
    logic         done_q, done_d;

    logic w_load_ready;
    logic w_load_fire;
    logic w_pre_en;
    logic w_pre_clr;
    logic w_tick;
    logic w_terminal;
    logic w_rearm;

    assign w_load_ready = (state_q == ST_IDLE) & ~bus.clear;
    assign w_load_fire  = bus.load_valid & w_load_ready;

    // Stop and clear both gate the prescaler, so they win over a same-cycle tick.
    assign w_pre_en   = (state_q == ST_RUN) & ~bus.stop & ~bus.clear;
    assign w_pre_clr  = bus.clear | (state_q == ST_IDLE);
    assign w_terminal = w_tick & (count_q <= W'(1));
    assign w_rearm    = bus.periodic & (reload_q != '0);

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en_i   (w_pre_en),
        .clr_i  (w_pre_clr),
        .tick_o (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!bus.clear && bus.start && !w_load_fire && (count_q != '0)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.clear) begin
                    state_d = ST_IDLE;
                end else if (bus.stop) begin
                    state_d = ST_PAUSE;
                end else if (w_terminal && !w_rearm) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAUSE: begin
                if (bus.clear) begin
                    state_d = ST_IDLE;
                end else if (bus.start) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (bus.clear) begin
            count_d = reload_q;
        end else if (w_load_fire) begin
            reload_d = bus.load_value;
            count_d  = bus.load_value;
        end else if ((state_q == ST_IDLE) && bus.start && (count_q == '0)) begin
            done_d = 1'b1;
        end else if (w_tick) begin
            if (w_terminal) begin
                done_d  = 1'b1;
                count_d = w_rearm ? reload_q : '0;
            end else begin
                count_d = count_q - W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        bus.load_ready = w_load_ready;
        bus.count      = count_q;
        bus.busy       = (state_q != ST_IDLE);
        bus.paused     = (state_q == ST_PAUSE);
        bus.done       = done_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_countdown_timer
//  Description : Self-checking bench for countdown_timer at PRESCALE 1 and 4.
//  Revision    : 1.0
// ============================================================================
module tb_countdown_timer;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;

    logic        clk;
    logic        rst;
    logic        lv;
    logic [31:0] lval;
    logic        per;
    logic        st;
    logic        sp;
    logic        clr;

    int errors = 0;
    int checks = 0;

    int          m_state  [2];
    int          m_pre    [2];
    logic [31:0] m_count  [2];
    logic [31:0] m_reload [2];
    logic        m_done   [2];

    countdown_timer_if #(.W(32)) if0 ();
    countdown_timer_if #(.W(32)) if1 ();

    assign if0.load_valid = lv;
    assign if0.load_value = lval;
    assign if0.periodic   = per;
    assign if0.start      = st;
    assign if0.stop       = sp;
    assign if0.clear      = clr;
    assign if1.load_valid = lv;
    assign if1.load_value = lval;
    assign if1.periodic   = per;
    assign if1.start      = st;
    assign if1.stop       = sp;
    assign if1.clear      = clr;

    countdown_timer #(.W(32), .PRESCALE(1)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    countdown_timer #(.W(32), .PRESCALE(4)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one step per rising edge, straight from the timer's rules.
    task automatic model_step(input int i);
        int p;
        bit tick;
        p = (i == 0) ? 1 : 4;
        if (rst) begin
            m_state[i] = S_IDLE; m_count[i] = 0; m_reload[i] = 0; m_pre[i] = 0; m_done[i] = 0;
            return;
        end
        m_done[i] = 0;
        if (clr) begin
            m_state[i] = S_IDLE; m_count[i] = m_reload[i]; m_pre[i] = 0;
        end else if (m_state[i] == S_IDLE) begin
            if (lv) begin
                m_reload[i] = lval; m_count[i] = lval;
            end else if (st) begin
                if (m_count[i] != 0) begin
                    m_state[i] = S_RUN; m_pre[i] = 0;
                end else begin
                    m_done[i] = 1;
                end
            end
        end else if (m_state[i] == S_RUN) begin
            if (sp) begin
                m_state[i] = S_PAUSE;
            end else begin
                tick     = (m_pre[i] == p - 1);
                m_pre[i] = tick ? 0 : m_pre[i] + 1;
                if (tick) begin
                    if (m_count[i] > 1) begin
                        m_count[i] = m_count[i] - 1;
                    end else begin
                        m_done[i] = 1;
                        if (per && m_reload[i] != 0) begin
                            m_count[i] = m_reload[i];
                        end else begin
                            m_count[i] = 0; m_state[i] = S_IDLE;
                        end
                    end
                end
            end
        end else begin
            if (st) m_state[i] = S_RUN;
        end
    endtask

    task automatic cmp_inst(input int i, input logic [31:0] c, input logic b,
                            input logic pz, input logic d, input logic r);
        check($sformatf("u%0d_count", i),  c, m_count[i]);
        check($sformatf("u%0d_busy", i),   {31'd0, b},  {31'd0, m_state[i] != S_IDLE});
        check($sformatf("u%0d_paused", i), {31'd0, pz}, {31'd0, m_state[i] == S_PAUSE});
        check($sformatf("u%0d_done", i),   {31'd0, d},  {31'd0, m_done[i]});
        check($sformatf("u%0d_ready", i),  {31'd0, r},  {31'd0, (m_state[i] == S_IDLE) && !clr});
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        #1;
        cmp_inst(0, if0.count, if0.busy, if0.paused, if0.done, if0.load_ready);
        cmp_inst(1, if1.count, if1.busy, if1.paused, if1.done, if1.load_ready);
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_clear();
        clr = 1'b1; step(); clr = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] v);
        lv = 1'b1; lval = v; step(); lv = 1'b0;
    endtask

    task automatic do_start();
        st = 1'b1; step(); st = 1'b0;
    endtask

    int first_done;
    int pulses;
    int busy_ok;
    logic [31:0] cnt_at_done;

    initial begin
        rst = 1'b0; lv = 1'b0; lval = '0; per = 1'b0; st = 1'b0; sp = 1'b0; clr = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_count", if0.count, 32'd0);
        check("rst_busy", {31'd0, if0.busy}, 32'd0);
        check("rst_done", {31'd0, if1.done}, 32'd0);
        step(); step();
        rst = 1'b0;

        // One-shot countdown from 3 at PRESCALE 1
        do_load(32'd3);
        check("t1_loaded", if0.count, 32'd3);
        do_start();
        check("t1_run_busy", {31'd0, if0.busy}, 32'd1);
        step(); check("t1_c2", if0.count, 32'd2);
        step(); check("t1_c1", if0.count, 32'd1);
        step();
        check("t1_c0", if0.count, 32'd0);
        check("t1_done", {31'd0, if0.done}, 32'd1);
        check("t1_idle", {31'd0, if0.busy}, 32'd0);
        step(); check("t1_done_gone", {31'd0, if0.done}, 32'd0);
        do_clear();

        // Periodic reload of 2 at PRESCALE 4: done every 8 clocks
        do_load(32'd2);
        per = 1'b1;
        do_start();
        first_done = -1; pulses = 0; busy_ok = 1; cnt_at_done = '1;
        for (int k = 1; k <= 17; k++) begin
            step();
            if (if1.done) begin
                pulses++;
                if (first_done < 0) first_done = k;
                if (k == 8) cnt_at_done = if1.count;
            end
            if (!if1.busy) busy_ok = 0;
        end
        check("t2_first_done", first_done, 32'd8);
        check("t2_pulses", pulses, 32'd2);
        check("t2_reloaded", cnt_at_done, 32'd2);
        check("t2_busy_kept", busy_ok, 32'd1);
        per = 1'b0;
        do_clear();

        // Pause at 3 for 10 clocks, then resume
        do_load(32'd5);
        do_start();
        step(); step();
        check("t3_at3", if0.count, 32'd3);
        sp = 1'b1;
        repeat (10) step();
        sp = 1'b0;
        check("t3_hold", if0.count, 32'd3);
        check("t3_paused", {31'd0, if0.paused}, 32'd1);
        do_start();
        check("t3_resumed", {31'd0, if0.paused}, 32'd0);
        step(); step(); step();
        check("t3_done", {31'd0, if0.done}, 32'd1);
        check("t3_c0", if0.count, 32'd0);

        // Zero load, and load blocked while running
        do_clear();
        do_load(32'd0);
        do_start();
        check("t4_zero_done", {31'd0, if0.done}, 32'd1);
        check("t4_zero_idle", {31'd0, if0.busy}, 32'd0);
        step();
        do_load(32'd5);
        do_start();
        lv = 1'b1; lval = 32'd9;
        #1 check("t4_ready_low", {31'd0, if0.load_ready}, 32'd0);
        step();
        lv = 1'b0;
        do_clear();
        check("t4_reload_kept", if0.count, 32'd5);

        // Clear mid-run, then clear+stop+start together
        do_load(32'd4);
        do_start();
        step(); step();
        check("t5_at2", if0.count, 32'd2);
        do_clear();
        check("t5_clr_count", if0.count, 32'd4);
        check("t5_clr_idle", {31'd0, if0.busy}, 32'd0);
        step();
        check("t5_no_done", {31'd0, if0.done}, 32'd0);
        do_start();
        step();
        clr = 1'b1; sp = 1'b1; st = 1'b1;
        step();
        clr = 1'b0; sp = 1'b0; st = 1'b0;
        check("t5_all_idle", {31'd0, if0.busy}, 32'd0);
        check("t5_all_count", if0.count, 32'd4);

        // Stop on the terminal tick, then asynchronous reset mid-run
        do_load(32'd2);
        do_start();
        step();
        check("t6_at1", if0.count, 32'd1);
        sp = 1'b1; step(); sp = 1'b0;
        check("t6_paused", {31'd0, if0.paused}, 32'd1);
        check("t6_hold1", if0.count, 32'd1);
        check("t6_no_done", {31'd0, if0.done}, 32'd0);
        step();
        check("t6_no_done2", {31'd0, if0.done}, 32'd0);
        do_start();
        check("t6_running", {31'd0, if0.busy}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_count", if0.count, 32'd0);
        check("t6_rst_busy", {31'd0, if0.busy}, 32'd0);
        check("t6_rst_done", {31'd0, if0.done}, 32'd0);
        check("t6_rst_busy_u1", {31'd0, if1.busy}, 32'd0);
        step(); step();
        rst = 1'b0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
